// File: rtl/alu_seq_nb.sv
// alu_seq_nb: multi-cycle arithmetic unit.
//   ADD/SUB complete in one cycle. MULT (shift-add) and DIV (restoring) take
//   WIDTH iterations and produce a 2*WIDTH hi/lo result. One operation is in
//   flight at a time: start is sampled only in idle, done pulses for one cycle
//   when the results are valid, and all outputs are registered.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        request, ignored unless idle
//   ALUop        00 ADD, 01 SUB, 10 MULT, 11 DIV
//   a, b         operands (latched on the accepted start edge)
//   busy         MULT/DIV iteration in progress
//   done         one-cycle pulse, results valid
//   s, cout      ADD/SUB result and carry-out (SUB: 1 = no borrow)
//   hi, lo       MULT product halves / DIV remainder and quotient
//   zero         result-zero flag of the last operation
//   div0         last DIV had a zero divisor
//
// Build option:
//   ALU_SEQ_SIGNED_EN  MULT/DIV treat operands as two's complement. The
//                      iteration runs on magnitudes; signs are reapplied as the
//                      result is written, so latency is unchanged.
module alu_seq_nb #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       ALUop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] hi_acc;   // MUL: partial product high / DIV: remainder
    logic [WIDTH-1:0] lo_acc;   // MUL: multiplier shifting out / DIV: quotient
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    iter;

    // Single-cycle add/sub: SUB is a + ~b + 1
    logic [WIDTH-1:0] b_addend;
    logic [WIDTH:0]   add_sum;

    always_comb begin
        b_addend = ALUop[0] ? ~b : b;
        add_sum  = {1'b0, a} + {1'b0, b_addend} + {{WIDTH{1'b0}}, ALUop[0]};
    end

    // Operand magnitudes fed into the unsigned iteration
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef ALU_SEQ_SIGNED_EN
    logic neg_res_q;   // product / quotient is negative
    logic neg_rem_q;   // remainder follows the dividend's sign

    always_comb begin
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    // One shift-add multiply step; the adder carry becomes the new top bit
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;

    always_comb begin
        mul_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, b_q} : '0);
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], lo_acc[WIDTH-1:1]};
    end

    // One restoring divide step. The shifted remainder is WIDTH+1 bits wide;
    // when the trial subtraction succeeds the difference always fits in WIDTH.
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nx;
    logic [WIDTH-1:0] div_quo_nx;

    always_comb begin
        div_sh     = {hi_acc, lo_acc[WIDTH-1]};
        div_ge     = div_sh >= {1'b0, b_q};
        div_rem_nx = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
        div_quo_nx = {lo_acc[WIDTH-2:0], div_ge};
    end

    // Final results as written into the output registers on the last step
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

    always_comb begin
`ifdef ALU_SEQ_SIGNED_EN
        prod_res = neg_res_q ? -{mul_hi_nx, mul_lo_nx} : {mul_hi_nx, mul_lo_nx};
        quo_res  = neg_res_q ? -div_quo_nx : div_quo_nx;
        rem_res  = neg_rem_q ? -div_rem_nx : div_rem_nx;
`else
        prod_res = {mul_hi_nx, mul_lo_nx};
        quo_res  = div_quo_nx;
        rem_res  = div_rem_nx;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            hi_acc    <= '0;
            lo_acc    <= '0;
            b_q       <= '0;
            iter      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            zero      <= 1'b0;
            div0      <= 1'b0;
`ifdef ALU_SEQ_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        iter <= '0;
                        unique case (ALUop)
                            2'b00, 2'b01: begin
                                s     <= add_sum[WIDTH-1:0];
                                cout  <= add_sum[WIDTH];
                                zero  <= (add_sum[WIDTH-1:0] == '0);
                                done  <= 1'b1;
                                state <= StDone;
                            end
                            2'b10: begin
                                hi_acc <= '0;
                                lo_acc <= a_mag;
                                b_q    <= b_mag;
                                busy   <= 1'b1;
                                state  <= StMul;
                            end
                            2'b11: begin
                                if (b == '0) begin
                                    // Divide by zero short-circuits to DONE
                                    hi    <= '0;
                                    lo    <= '0;
                                    div0  <= 1'b1;
                                    zero  <= 1'b1;
                                    done  <= 1'b1;
                                    state <= StDone;
                                end else begin
                                    hi_acc <= '0;
                                    lo_acc <= a_mag;
                                    b_q    <= b_mag;
                                    busy   <= 1'b1;
                                    state  <= StDiv;
                                end
                            end
                        endcase
`ifdef ALU_SEQ_SIGNED_EN
                        neg_res_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem_q <= a[WIDTH-1];
`endif
                    end
                end
                StMul: begin
                    hi_acc <= mul_hi_nx;
                    lo_acc <= mul_lo_nx;
                    iter   <= iter + CW'(1);
                    if (iter == LastIter) begin
                        hi    <= prod_res[2*WIDTH-1:WIDTH];
                        lo    <= prod_res[WIDTH-1:0];
                        zero  <= (prod_res == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDiv: begin
                    hi_acc <= div_rem_nx;
                    lo_acc <= div_quo_nx;
                    iter   <= iter + CW'(1);
                    if (iter == LastIter) begin
                        hi    <= rem_res;
                        lo    <= quo_res;
                        zero  <= (quo_res == '0);
                        div0  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    // start is not accepted in the done cycle
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_nb.sv
// Bench for alu_seq_nb at WIDTH=32: directed table, randomized ops against a
// 64-bit arithmetic reference model, and a mid-operation reset sequence.
module tb_alu_seq_nb;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    ALUop;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  s;
    logic          cout;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          zero;
    logic          div0;

    alu_seq_nb #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ALUop (ALUop),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .hi    (hi),
        .zero  (zero),
        .lo    (lo),
        .div0  (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: last value of every held result
    logic [31:0] m_s, m_hi, m_lo;
    logic        m_cout, m_zero, m_div0;

    // Outputs captured in the done cycle
    logic [31:0] o_s, o_hi, o_lo;
    logic        o_cout, o_zero, o_div0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] va, vb;
        bit          spam;
        logic [31:0] es;
        logic        ec;
        logic [31:0] eh, el;
        logic        ez, ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] va, vb, input bit spam,
                                input logic [31:0] es, input logic ec, input logic [31:0] eh,
                                input logic [31:0] el, input logic ez, ed);
        vec_t v;
        v.op = op; v.va = va; v.vb = vb; v.spam = spam;
        v.es = es; v.ec = ec; v.eh = eh; v.el = el; v.ez = ez; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] bv);
        if (op == 2'b10) return int'(W);
        if (op == 2'b11 && bv != 0) return int'(W);
        return 0;
    endfunction

    task automatic model_reset();
        m_s = '0; m_hi = '0; m_lo = '0; m_cout = 1'b0; m_zero = 1'b0; m_div0 = 1'b0;
    endtask

    task automatic model_op(input logic [1:0] op, input logic [31:0] av, bv);
        logic [63:0] ut;
        longint      sp, sq, sr;
        int          sa, sb;
        sa = av;
        sb = bv;
        case (op)
            2'b00: begin
                ut = {32'b0, av} + {32'b0, bv};
                m_s = ut[31:0]; m_cout = ut[32]; m_zero = (m_s == 0);
            end
            2'b01: begin
                m_s = av - bv; m_cout = (av >= bv); m_zero = (m_s == 0);
            end
            2'b10: begin
`ifdef ALU_SEQ_SIGNED_EN
                sp = longint'(sa) * longint'(sb);
                ut = sp;
`else
                ut = {32'b0, av} * {32'b0, bv};
`endif
                m_hi = ut[63:32]; m_lo = ut[31:0]; m_zero = (ut == 0);
            end
            default: begin
                if (bv == 0) begin
                    m_hi = '0; m_lo = '0; m_div0 = 1'b1; m_zero = 1'b1;
                end else begin
`ifdef ALU_SEQ_SIGNED_EN
                    sq = longint'(sa) / longint'(sb);
                    sr = longint'(sa) % longint'(sb);
                    m_lo = sq[31:0]; m_hi = sr[31:0];
`else
                    m_lo = av / bv; m_hi = av % bv;
`endif
                    m_div0 = 1'b0; m_zero = (m_lo == 0);
                end
            end
        endcase
    endtask

    // Issue one op, count cycles to done, check busy along the way and that
    // done is a single pulse with no start accepted in the done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] av, bv, input bit spam,
                          output int lat, output int busy_err, output int post_err);
        @(negedge clk);
        ALUop = op; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; ALUop = 2'($urandom);
        lat = -1; busy_err = 0; post_err = 0;
        for (int i = 0; i <= int'(W) + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (busy !== (exp_lat(op, bv) != 0)) busy_err++;
            if (spam) begin
                start = 1'b1; ALUop = 2'b10;
            end
        end
        if (busy !== 1'b0) busy_err++;
        o_s = s; o_cout = cout; o_hi = hi; o_lo = lo; o_zero = zero; o_div0 = div0;
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) post_err++;
        start = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [31:0] es, input logic ec,
                             input logic [31:0] eh, el, input logic ez, ed,
                             input int elat, lat, busy_err, post_err);
        chk({tag, ".s"}, o_s, es);
        chk({tag, ".cout"}, o_cout, ec);
        chk({tag, ".hi"}, o_hi, eh);
        chk({tag, ".lo"}, o_lo, el);
        chk({tag, ".zero"}, o_zero, ez);
        chk({tag, ".div0"}, o_div0, ed);
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".busy"}, busy_err, 0);
        chk({tag, ".single_done"}, post_err, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, be, pe, cnt;
        logic [1:0]  op;
        logic [31:0] va, vb;

        rst_n = 1'b0; start = 1'b0; ALUop = '0; a = '0; b = '0;
        model_reset();

        // Directed vectors; held fields follow from the preceding entries
        tbl.push_back(mk(2'b00, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1, 32'h0, 32'h0, 1, 0));
        tbl.push_back(mk(2'b01, 32'd5, 32'd7, 0, 32'hFFFF_FFFE, 0, 32'h0, 32'h0, 0, 0));
`ifdef ALU_SEQ_SIGNED_EN
        tbl.push_back(mk(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
                         32'hFFFF_FFFE, 0, 32'h0, 32'h1, 0, 0));
`else
        tbl.push_back(mk(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
                         32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 32'h1, 0, 0));
`endif
        tbl.push_back(mk(2'b11, 32'd100, 32'd7, 0, 32'hFFFF_FFFE, 0, 32'd2, 32'd14, 0, 0));
        tbl.push_back(mk(2'b11, 32'd9, 32'd0, 1, 32'hFFFF_FFFE, 0, 32'd0, 32'd0, 1, 1));
        tbl.push_back(mk(2'b00, 32'd1, 32'd2, 0, 32'd3, 0, 32'd0, 32'd0, 0, 1));
        tbl.push_back(mk(2'b10, 32'd0, 32'd12345, 0, 32'd3, 0, 32'd0, 32'd0, 1, 1));
        tbl.push_back(mk(2'b11, 32'd5, 32'd9, 1, 32'd3, 0, 32'd5, 32'd0, 1, 0));
`ifdef ALU_SEQ_SIGNED_EN
        tbl.push_back(mk(2'b10, 32'hFFFF_FFFD, 32'd5, 0,
                         32'd3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0));
        tbl.push_back(mk(2'b11, 32'hFFFF_FFF9, 32'd2, 0,
                         32'd3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0));
        tbl.push_back(mk(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0,
                         32'd3, 0, 32'h0, 32'h8000_0000, 0, 0));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset.flags", {busy, done, cout, zero, div0}, 0);
        chk("reset.s", s, 0);
        chk("reset.hi", hi, 0);
        chk("reset.lo", lo, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].va, tbl[i].vb, tbl[i].spam, lat, be, pe);
            model_op(tbl[i].op, tbl[i].va, tbl[i].vb);
            check_res($sformatf("vec%0d", i), tbl[i].es, tbl[i].ec, tbl[i].eh, tbl[i].el,
                      tbl[i].ez, tbl[i].ed, exp_lat(tbl[i].op, tbl[i].vb), lat, be, pe);
        end

        // Randomized ops against the reference model
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            va = $urandom;
            case ($urandom_range(0, 7))
                0:       vb = '0;
                1:       vb = $urandom_range(1, 15);
                2:       vb = va;
                default: vb = $urandom;
            endcase
            run_op(op, va, vb, bit'($urandom_range(0, 1)), lat, be, pe);
            model_op(op, va, vb);
            check_res($sformatf("rnd%0d", k), m_s, m_cout, m_hi, m_lo, m_zero, m_div0,
                      exp_lat(op, vb), lat, be, pe);
        end

        // Reset in cycle N+10 of a MULT: everything clears, no done pulse
        @(negedge clk);
        ALUop = 2'b10; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("midrst.busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.flags", {busy, done, cout, zero, div0}, 0);
        chk("midrst.s", s, 0);
        chk("midrst.hi", hi, 0);
        chk("midrst.lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) cnt++;
        end
        chk("midrst.no_done", cnt, 0);
        model_reset();

        run_op(2'b00, 32'd2, 32'd3, 0, lat, be, pe);
        model_op(2'b00, 32'd2, 32'd3);
        chk("postrst.s_is_5", o_s, 32'd5);
        check_res("postrst", m_s, m_cout, m_hi, m_lo, m_zero, m_div0, 0, lat, be, pe);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
